// File: rtl/barrel_shifter.sv
// barrel_shifter: log-stage LSR/LSL/ASR/ROR shifter with registered copy; BARREL_SHIFTER_STATUS_EN adds zero_q/lost_q.
module barrel_shifter #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           a,
    input  logic [$clog2(WIDTH)-1:0]   b,
    input  logic [1:0]                 op,
    input  logic                       in_valid,
    output logic [WIDTH-1:0]           o,
    output logic [WIDTH-1:0]           o_q,
    output logic                       o_valid
`ifdef BARREL_SHIFTER_STATUS_EN
    ,
    output logic                       zero_q,
    output logic                       lost_q
`endif
);
    localparam int SHW = $clog2(WIDTH);
    logic [WIDTH-1:0] s [SHW+1];
    logic [WIDTH-1:0] ar, rr;
    always_comb begin
        ar = '0;
        rr = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ar[i] = a[WIDTH-1-i];
            rr[i] = s[SHW][WIDTH-1-i];
        end
    end
    // LSL runs through the right-shift cascade on a bit-reversed operand
    assign s[0] = (op == 2'b01) ? ar : a;
    assign o = (op == 2'b01) ? rr : s[SHW];
`ifdef BARREL_SHIFTER_STATUS_EN
    logic [SHW:0] l;
    assign l[0] = 1'b0;
`endif
    genvar k;
    generate
        for (k = 0; k < SHW; k++) begin : g_stage
            localparam int N = 2 ** k;
            logic [N-1:0] f;
            assign f = (op == 2'b11) ? s[k][N-1:0] : (op == 2'b10) ? {N{a[WIDTH-1]}} : '0;
            assign s[k+1] = b[k] ? {f, s[k][WIDTH-1:N]} : s[k];
`ifdef BARREL_SHIFTER_STATUS_EN
            assign l[k+1] = l[k] | (b[k] & (op != 2'b11) & (|s[k][N-1:0]));
`endif
        end
    endgenerate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q     <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= in_valid;
            if (in_valid) o_q <= o;
        end
    end
`ifdef BARREL_SHIFTER_STATUS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            lost_q <= 1'b0;
        end else if (in_valid) begin
            zero_q <= (o == '0);
            lost_q <= l[SHW];
        end
    end
`endif
endmodule

// File: tb/tb_barrel_shifter.sv
// tb_barrel_shifter: directed self-checking bench for barrel_shifter.
module tb_barrel_shifter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0;
    logic [3:0]  b = '0;
    logic [1:0]  op = '0;
    logic        in_valid = 1'b0;
    logic [15:0] o, o_q;
    logic        o_valid;
    int checks = 0;
    int errors = 0;
`ifdef BARREL_SHIFTER_STATUS_EN
    logic zero_q, lost_q;
`endif

    barrel_shifter #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .in_valid(in_valid),
        .o(o), .o_q(o_q), .o_valid(o_valid)
`ifdef BARREL_SHIFTER_STATUS_EN
        , .zero_q(zero_q), .lost_q(lost_q)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic comb(input logic [1:0] p, input logic [15:0] x, input logic [3:0] s,
                        input logic [15:0] exp, input string tag);
        op = p; a = x; b = s;
        #1 chk(tag, o, exp);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_o_q", o_q, 16'h0000);
        chk("rst_o_valid", {15'b0, o_valid}, 16'h0000);
        comb(2'b00, 16'h0100, 4'd8, 16'h0001, "lsr_8");
        comb(2'b00, 16'h0010, 4'd4, 16'h0001, "lsr_4");
        comb(2'b00, 16'h0004, 4'd2, 16'h0001, "lsr_2");
        comb(2'b00, 16'h0002, 4'd1, 16'h0001, "lsr_1");
        comb(2'b00, 16'h0080, 4'd7, 16'h0001, "lsr_7");
        comb(2'b00, 16'h8000, 4'd15, 16'h0001, "lsr_15");
        comb(2'b00, 16'hABCD, 4'd0, 16'hABCD, "lsr_0");
        comb(2'b00, 16'hFFFF, 4'd15, 16'h0001, "lsr_ones_15");
        comb(2'b01, 16'h0001, 4'd15, 16'h8000, "lsl_15");
        comb(2'b01, 16'hABCD, 4'd4, 16'hBCD0, "lsl_4");
        comb(2'b01, 16'hABCD, 4'd0, 16'hABCD, "lsl_0");
        comb(2'b10, 16'h8000, 4'd15, 16'hFFFF, "asr_15");
        comb(2'b10, 16'h4000, 4'd14, 16'h0001, "asr_pos_14");
        comb(2'b10, 16'h8F00, 4'd4, 16'hF8F0, "asr_4");
        comb(2'b10, 16'h8000, 4'd0, 16'h8000, "asr_0");
        comb(2'b11, 16'h0001, 4'd1, 16'h8000, "ror_1");
        comb(2'b11, 16'h1234, 4'd4, 16'h4123, "ror_4");
        comb(2'b11, 16'hABCD, 4'd0, 16'hABCD, "ror_0");
        comb(2'b00, 16'h00F0, 4'd4, 16'h000F, "lsr_f0");
        cyc();
        chk("rst_hold_o_q", o_q, 16'h0000);
        chk("rst_hold_o_valid", {15'b0, o_valid}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; op = 2'b00; a = 16'h00F0; b = 4'd4;
        cyc();
        chk("reg_o_q", o_q, 16'h000F);
        chk("reg_o_valid", {15'b0, o_valid}, 16'h0001);
        in_valid = 1'b0; a = 16'h1111; b = 4'd1;
        cyc();
        chk("hold_o_q", o_q, 16'h000F);
        chk("hold_o_valid", {15'b0, o_valid}, 16'h0000);
        in_valid = 1'b1; op = 2'b01; a = 16'h1234; b = 4'd4;
        cyc();
        chk("b2b1_o_q", o_q, 16'h2340);
        op = 2'b11; a = 16'h8001; b = 4'd1;
        cyc();
        chk("b2b2_o_q", o_q, 16'hC000);
        chk("b2b2_o_valid", {15'b0, o_valid}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("async_o_q", o_q, 16'h0000);
        chk("async_o_valid", {15'b0, o_valid}, 16'h0000);
        cyc();
        chk("rst_ovr_o_q", o_q, 16'h0000);
        chk("rst_ovr_o_valid", {15'b0, o_valid}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        op = 2'b00; a = 16'h0100; b = 4'd8;
        cyc();
        chk("post_rst_o_q", o_q, 16'h0001);
        chk("post_rst_o_valid", {15'b0, o_valid}, 16'h0001);
`ifdef BARREL_SHIFTER_STATUS_EN
        op = 2'b00; a = 16'h0003; b = 4'd1;
        cyc();
        chk("st_lsr3_o_q", o_q, 16'h0001);
        chk("st_lsr3_zero", {15'b0, zero_q}, 16'h0000);
        chk("st_lsr3_lost", {15'b0, lost_q}, 16'h0001);
        a = 16'h0001; b = 4'd1;
        cyc();
        chk("st_lsr1_zero", {15'b0, zero_q}, 16'h0001);
        chk("st_lsr1_lost", {15'b0, lost_q}, 16'h0001);
        op = 2'b11; a = 16'hFFFF; b = 4'd5;
        cyc();
        chk("st_ror_zero", {15'b0, zero_q}, 16'h0000);
        chk("st_ror_lost", {15'b0, lost_q}, 16'h0000);
        op = 2'b01; a = 16'h8000; b = 4'd1;
        cyc();
        chk("st_lsl_zero", {15'b0, zero_q}, 16'h0001);
        chk("st_lsl_lost", {15'b0, lost_q}, 16'h0001);
        op = 2'b01; a = 16'h0001; b = 4'd3;
        cyc();
        chk("st_lsl_nolost", {15'b0, lost_q}, 16'h0000);
        op = 2'b00; a = 16'hFFFF; b = 4'd0;
        cyc();
        chk("st_b0_lost", {15'b0, lost_q}, 16'h0000);
        in_valid = 1'b0; a = 16'h0000;
        cyc();
        chk("st_hold_lost", {15'b0, lost_q}, 16'h0000);
        chk("st_hold_zero", {15'b0, zero_q}, 16'h0000);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
